// File: rtl/ddr3_arb_pkg.sv
// ============================================================================
// Module      : ddr3_arb_pkg
// Description : Shared types and default widths for the DDR3 write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr3_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } statetype;

    localparam int ADDR_WIDTH_DEF = 27;
    localparam int DATA_WIDTH_DEF = 256;
    localparam int BC_WIDTH_DEF   = 8;
    localparam int CNT_WIDTH      = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, searching from last_grant+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_WIDTH   = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_WIDTH-1:0]   last_grant,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_WIDTH-1:0]   gnt_index,
    output logic                   any_req
);

    always_comb begin
        int   idx;
        logic found;
        gnt       = '0;
        gnt_index = '0;
        any_req   = |req;
        found     = 1'b0;
        idx       = 0;
        // Offset 1..N so the previous owner is checked last.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_grant) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_index = IDX_WIDTH'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr3_write_arbiter.sv
// ============================================================================
// Module      : ddr3_write_arbiter
// Description : Burst-granular round-robin sharing of one Avalon-MM write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_write_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int BC_WIDTH    = BC_WIDTH_DEF
) (
    input  logic                             ddr3_clk,
    input  logic                             ddr3_clk_reset_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_data,
    input  logic [NUM_MASTERS-1:0]           m_write,
    input  logic [NUM_MASTERS*BC_WIDTH-1:0]  m_burstcount,
    output logic [NUM_MASTERS-1:0]           m_waitrequest,
    output logic [ADDR_WIDTH-1:0]            ddr3_write_address,
    output logic [DATA_WIDTH-1:0]            ddr3_write_data,
    output logic                             ddr3_write,
    output logic [BC_WIDTH-1:0]              ddr3_burstcount,
    input  logic                             ddr3_waitrequest,
    output logic [NUM_MASTERS-1:0]           grant,
    output logic [NUM_MASTERS*CNT_WIDTH-1:0] bursts_done
);

    localparam int IDX_WIDTH = $clog2(NUM_MASTERS);
    localparam logic [BC_WIDTH-1:0]  BC_ONE  = {{(BC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    statetype                state;
    statetype                next_state;
    logic [IDX_WIDTH-1:0]    last_grant;
    logic [BC_WIDTH-1:0]     burst_len;
    logic [BC_WIDTH-1:0]     beat;
    logic [NUM_MASTERS-1:0]  arb_gnt;
    logic [IDX_WIDTH-1:0]    arb_idx;
    logic                    arb_any;
    logic [BC_WIDTH-1:0]     new_bc;
    logic                    accept;
    logic                    last_beat;
    int                      owner;
    int                      pick;

    // last_grant doubles as the owner index while in ST_BURST.
    assign owner     = int'(last_grant);
    assign pick      = int'(arb_idx);
    assign new_bc    = m_burstcount[pick*BC_WIDTH +: BC_WIDTH];
    assign accept    = (state == ST_BURST) && ddr3_write && !ddr3_waitrequest;
    assign last_beat = (beat == burst_len - BC_ONE);

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_rr_arbiter (
        .req        (m_write),
        .last_grant (last_grant),
        .gnt        (arb_gnt),
        .gnt_index  (arb_idx),
        .any_req    (arb_any)
    );

    always_comb begin
        next_state         = state;
        m_waitrequest      = '1;
        ddr3_write         = 1'b0;
        ddr3_write_address = '0;
        ddr3_write_data    = '0;
        ddr3_burstcount    = '0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                ddr3_write            = m_write[owner];
                ddr3_write_address    = m_address[owner*ADDR_WIDTH +: ADDR_WIDTH];
                ddr3_write_data       = m_write_data[owner*DATA_WIDTH +: DATA_WIDTH];
                ddr3_burstcount       = burst_len;
                m_waitrequest[owner]  = ddr3_waitrequest;
                if (accept && last_beat) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            last_grant  <= IDX_WIDTH'(NUM_MASTERS - 1);
            burst_len   <= '0;
            beat        <= '0;
            bursts_done <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE) begin
                if (arb_any) begin
                    grant      <= arb_gnt;
                    last_grant <= arb_idx;
                    // A zero burstcount is treated as a single-beat burst.
                    burst_len  <= (new_bc == '0) ? BC_ONE : new_bc;
                    beat       <= '0;
                end
            end else if (accept) begin
                if (last_beat) begin
                    bursts_done[owner*CNT_WIDTH +: CNT_WIDTH] <=
                        bursts_done[owner*CNT_WIDTH +: CNT_WIDTH] + CNT_ONE;
                    grant <= '0;
                end else begin
                    beat <= beat + BC_ONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr3_write_arbiter.sv
// ============================================================================
// Module      : tb_ddr3_write_arbiter
// Description : Randomized scoreboard bench with a behavioural arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr3_write_arbiter;
    import ddr3_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 27;
    localparam int DW = 256;
    localparam int BW = 8;
    localparam int CW = 16;
    localparam int NB = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*AW-1:0] m_address;
    logic [N*DW-1:0] m_write_data;
    logic [N-1:0]    m_write;
    logic [N*BW-1:0] m_burstcount;
    logic [N-1:0]    m_waitrequest;
    logic [AW-1:0]   ddr3_write_address;
    logic [DW-1:0]   ddr3_write_data;
    logic            ddr3_write;
    logic [BW-1:0]   ddr3_burstcount;
    logic            ddr3_waitrequest = 1'b0;
    logic [N-1:0]    grant;
    logic [N*CW-1:0] bursts_done;

    logic          drv_write [N];
    logic [AW-1:0] drv_addr  [N];
    logic [DW-1:0] drv_data  [N];
    logic [BW-1:0] drv_bc    [N];

    always_comb begin
        m_write      = '0;
        m_address    = '0;
        m_write_data = '0;
        m_burstcount = '0;
        for (int i = 0; i < N; i++) begin
            m_write[i]                 = drv_write[i];
            m_address[i*AW +: AW]      = drv_addr[i];
            m_write_data[i*DW +: DW]   = drv_data[i];
            m_burstcount[i*BW +: BW]   = drv_bc[i];
        end
    end

    ddr3_write_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BC_WIDTH    (BW)
    ) dut (
        .ddr3_clk           (clk),
        .ddr3_clk_reset_n   (rst_n),
        .m_address          (m_address),
        .m_write_data       (m_write_data),
        .m_write            (m_write),
        .m_burstcount       (m_burstcount),
        .m_waitrequest      (m_waitrequest),
        .ddr3_write_address (ddr3_write_address),
        .ddr3_write_data    (ddr3_write_data),
        .ddr3_write         (ddr3_write),
        .ddr3_burstcount    (ddr3_burstcount),
        .ddr3_waitrequest   (ddr3_waitrequest),
        .grant              (grant),
        .bursts_done        (bursts_done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            first;
    } beat_t;
    beat_t expq [N][$];

    // Controller waitrequest: always ready, random stalls, or strict 1/0 toggling.
    int wr_mode = 0;
    bit wr_force0 = 1'b0;
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc % 64 == 0) wr_mode = $urandom_range(0, 2);
            if (wr_force0)         ddr3_waitrequest = 1'b0;
            else if (wr_mode == 0) ddr3_waitrequest = 1'b0;
            else if (wr_mode == 1) ddr3_waitrequest = ($urandom_range(0, 3) == 0);
            else                   ddr3_waitrequest = ~ddr3_waitrequest;
        end
    end

    // Reference model: round-robin at burst granularity with one idle cycle between bursts.
    bit mon_en = 1'b1;
    bit mdl_busy = 1'b0;
    int mdl_owner = 0;
    int mdl_last = N - 1;
    int mdl_left = 0;
    logic [BW-1:0] mdl_bc = '0;
    int done_cnt [N];

    initial begin
        beat_t b;
        logic [N-1:0] eg;
        logic [N-1:0] ew;
        int c;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (!mdl_busy) begin
                    check("idle_grant", DW'(grant), '0);
                    check("idle_bus", DW'({ddr3_write, ddr3_write_address, ddr3_burstcount}), '0);
                    check("idle_data", ddr3_write_data, '0);
                    check("idle_mwait", DW'(m_waitrequest), DW'({N{1'b1}}));
                    for (int k = 1; k <= N; k++) begin
                        c = (mdl_last + k) % N;
                        if (!mdl_busy && drv_write[c]) begin
                            mdl_busy  = 1'b1;
                            mdl_owner = c;
                            mdl_last  = c;
                            mdl_left  = (drv_bc[c] == 0) ? 1 : int'(drv_bc[c]);
                            mdl_bc    = BW'(mdl_left);
                        end
                    end
                end else begin
                    eg = '0;
                    eg[mdl_owner] = 1'b1;
                    ew = '1;
                    ew[mdl_owner] = ddr3_waitrequest;
                    check("grant", DW'(grant), DW'(eg));
                    check("write_mux", DW'(ddr3_write), DW'(drv_write[mdl_owner]));
                    check("mwait", DW'(m_waitrequest), DW'(ew));
                    check("burstcount", DW'(ddr3_burstcount), DW'(mdl_bc));
                    if (ddr3_write && !ddr3_waitrequest) begin
                        if (expq[mdl_owner].size() == 0) begin
                            check("unexpected_beat", 1, 0);
                        end else begin
                            b = expq[mdl_owner].pop_front();
                            check("data", ddr3_write_data, b.data);
                            if (b.first) check("address", DW'(ddr3_write_address), DW'(b.addr));
                        end
                        mdl_left--;
                        if (mdl_left == 0) begin
                            mdl_busy = 1'b0;
                            done_cnt[mdl_owner]++;
                        end
                    end
                end
            end
        end
    end

    bit drv_done [N];

    task automatic drive_master(input int m, input int nbursts);
        logic [DW-1:0] d [8];
        logic [BW-1:0] bc;
        logic [AW-1:0] addr;
        int  n;
        int  wd;
        bit  acc;
        beat_t e;
        @(posedge clk);
        #1;
        for (int b = 0; b < nbursts; b++) begin
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0) begin
                @(posedge clk);
                #1;
            end
            bc   = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom_range(1, 8));
            n    = (bc == 0) ? 1 : int'(bc);
            addr = AW'($urandom());
            for (int k = 0; k < n; k++) begin
                for (int w = 0; w < DW / 32; w++) d[k][w*32 +: 32] = $urandom();
                e.addr  = addr;
                e.data  = d[k];
                e.first = (k == 0);
                expq[m].push_back(e);
            end
            drv_addr[m] = addr;
            drv_bc[m]   = bc;
            for (int k = 0; k < n; k++) begin
                drv_data[m] = d[k];
                if (k > 0 && $urandom_range(0, 5) == 0) begin
                    drv_write[m] = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                if (k == 2 && $urandom_range(0, 1) == 1) drv_bc[m] = BW'($urandom_range(0, 8));
                drv_write[m] = 1'b1;
                acc = 1'b0;
                wd  = 0;
                while (!acc) begin
                    @(negedge clk);
                    acc = !m_waitrequest[m];
                    @(posedge clk);
                    #1;
                    wd++;
                    if (wd > 2000) begin
                        check("beat_timeout", 1, 0);
                        drv_write[m] = 1'b0;
                        drv_done[m]  = 1'b1;
                        return;
                    end
                end
            end
            drv_write[m] = 1'b0;
        end
        drv_done[m] = 1'b1;
    endtask

    initial begin
        int cnt;
        bit ok;
        for (int i = 0; i < N; i++) begin
            drv_write[i] = 1'b0;
            drv_addr[i]  = '0;
            drv_data[i]  = '0;
            drv_bc[i]    = '0;
            drv_done[i]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", DW'(grant), '0);
        check("rst_mwait", DW'(m_waitrequest), DW'({N{1'b1}}));
        check("rst_write", DW'(ddr3_write), '0);
        check("rst_done", DW'(bursts_done), '0);
        rst_n = 1'b1;

        fork
            drive_master(0, NB);
            drive_master(1, NB);
        join
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check("model_done", DW'(done_cnt[i]), DW'(NB));
            check("bursts_done", DW'(bursts_done[i*CW +: CW]), DW'(NB));
            check("queue_empty", DW'(expq[i].size()), '0);
        end

        // Reset in the middle of a burst, then check master 0 wins first.
        mon_en = 1'b0;
        wr_force0 = 1'b1;
        @(posedge clk);
        #1;
        drv_addr[0]  = 27'h155_AAAA;
        drv_bc[0]    = 8'd8;
        drv_data[0]  = {8{32'hC0DE_0000}};
        drv_write[0] = 1'b1;
        cnt = 0;
        ok  = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (ddr3_write && !ddr3_waitrequest) cnt++;
            if (cnt == 4) ok = 1'b1;
        end
        check("reach_beat4", DW'(ok), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant", DW'(grant), '0);
        check("async_mwait", DW'(m_waitrequest), DW'({N{1'b1}}));
        check("async_write", DW'(ddr3_write), '0);
        check("async_done", DW'(bursts_done), '0);
        drv_addr[1]  = 27'h0AA_5555;
        drv_bc[1]    = 8'd4;
        drv_write[1] = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_grant", DW'(grant), DW'(2'b01));
        check("post_rst_write", DW'(ddr3_write), 1);
        check("post_rst_addr", DW'(ddr3_write_address), DW'(27'h155_AAAA));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddr3_write_arbiter.md
Name: ddr3_write_arbiter

Overview:
- Shares one Avalon-MM burst write port of the DDR3 controller between num_masters pixel-writer masters, for example left/right camera writers.
- Each master issues fixed-length bursts: address and burstcount on the first beat, then burstcount data beats.
- Grants are round-robin at burst granularity. A grant is held until the granted master's last beat is accepted, so bursts from different masters never interleave.
- Sits between the pixel writers and the DDR3 controller, in the ddr3_clk domain.

Parameters:
num_masters, 2, number of requesting write masters (2..8)
addr_width, 27, Avalon word address width
data_width, 256, beat data width
bc_width, 8, burstcount width

Ports:
ddr3_clk  in  1  controller clock; all logic is on this clock
ddr3_clk_reset_n  in  1  asynchronous active-low reset
m_address  in  num_masters*addr_width  per-master address, master i at slice i
m_write_data  in  num_masters*data_width  per-master beat data
m_write  in  num_masters  per-master write request/beat valid
m_burstcount  in  num_masters*bc_width  per-master burst length
m_waitrequest  out  num_masters  per-master stall
ddr3_write_address  out  addr_width  to controller
ddr3_write_data  out  data_width  to controller
ddr3_write  out  1  to controller
ddr3_burstcount  out  bc_width  to controller
ddr3_waitrequest  in  1  from controller
grant  out  num_masters  one-hot current owner; all zero when idle
bursts_done  out  num_masters*16  per-master completed-burst counters, wrap at 16 bits

Behaviour:
- Reset, asynchronous, ddr3_clk_reset_n=0:
  - state=ST_IDLE, grant=0, beat counter=0, bursts_done=0.
  - last_grant=num_masters-1, so master 0 wins first.
  - m_waitrequest=all ones, ddr3_write=0.
- Outputs while no grant: ddr3_write=0, ddr3_write_address=0, ddr3_write_data=0, ddr3_burstcount=0.

States:
- ST_IDLE:
  - All m_waitrequest=1.
  - If any m_write is high, pick the first requester at or after (last_grant+1) mod num_masters.
  - Register it in grant and last_grant, latch its m_burstcount into burst_len, set beat=0, go to ST_BURST.
  - Grant decision is registered: one cycle of latency from a request to ddr3_write.
- ST_BURST:
  - ddr3_* outputs are a combinational mux of the granted master's signals.
  - Granted master sees m_waitrequest=ddr3_waitrequest; all other masters see 1.
  - A beat is accepted when ddr3_write=1 and ddr3_waitrequest=0; beat then increments.
  - When the master deasserts m_write mid-burst, ddr3_write=0 and beat holds. This is a legal Avalon bubble, and the grant is kept.
  - On acceptance of beat burst_len-1:
    - increment bursts_done[grant];
    - clear grant;
    - go to ST_IDLE.
  - ST_IDLE therefore always lasts at least one cycle between bursts, which is the fairness point.
- ddr3_burstcount is driven from the latched burst_len, not live m_burstcount. A master changing burstcount mid-burst has no effect.
- burstcount=0 is illegal: it is latched as 1 and the burst ends after one beat.
- Round-robin check: requests from all masters asserted continuously give grants 0,1,..,N-1,0,…
  - A master that is not requesting is skipped with no lost cycle.
- Simultaneous final-beat acceptance and a new request from the same master: that master does not win the next ST_IDLE if any other master is requesting.
- ddr3_waitrequest held high indefinitely: the arbiter stalls in ST_BURST with no timeout and no grant change.
- Reset asserted mid-burst: immediate return to reset values. The DDR3 controller and writers must be reset in the same domain; partial bursts are abandoned.
- Slice widths are exact, with no truncation; beat counter width is bc_width.

Decomposition:
- Package ddr3_arb_pkg:
  - statetype enum {ST_IDLE, ST_BURST};
  - localparam defaults for addr_width, data_width, bc_width;
  - counter width constant (16).
- Sub-module rr_arbiter, purely combinational:
  - inputs: req[num_masters], last_grant index;
  - outputs: one-hot gnt, gnt_index, any_req.
  - Instantiated once; the registering stays in ddr3_write_arbiter.

Test Plan:
- Reset then master 0 requests with burstcount=8, waitrequest=0 → ddr3_write rises 1 cycle after m_write; 8 beats with data matching m_write_data; grant=01 for those 8 cycles; bursts_done[0]=1; then ST_IDLE.
- Both masters request continuously with burstcount 8 → bursts alternate 0,1,0,1; no data beat from master 1 ever appears during a master 0 burst; ddr3_address matches the owner's address on each first beat.
- ddr3_waitrequest toggles 1,0 every cycle during a burst → exactly 8 accepted beats over 16 cycles; m_waitrequest of the non-owner stays 1 throughout.
- Granted master drops m_write for 3 cycles after beat 2 → ddr3_write=0 for those cycles; grant held; burst completes with beats 3..7.
- m_burstcount changes from 8 to 2 during a burst → the burst still completes 8 beats; a burstcount=0 request completes after 1 beat.
- ddr3_clk_reset_n pulsed low at beat 4 → grant=0, m_waitrequest=all ones and ddr3_write=0 asynchronously; after release, master 0 wins first.
